ibuff_align_ctrl: RTL and testbench

Parcel-aligning instruction buffer controller between the fetch stage and predecode.
- Accepts 4-byte-aligned 32-bit fetch words as two 16-bit parcels and queues them in a small circular parcel FIFO.
- Sequences one instruction per cycle into predecode: 1 parcel for compressed instructions, 2 parcels for 32-bit ones, including 32-bit instructions straddling two fetch words.
- Tracks the instruction PC and handles redirect flushes, including redirects to a half-word (pc[1]=1) target.

---
 rtl/ibuff_align_ctrl_pkg.sv | 22 ++
 rtl/ibuff_align_ctrl_parcel_fifo.sv | 78 +++++++
 rtl/ibuff_align_ctrl.sv | 105 ++++++++++
 tb/tb_ibuff_align_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ibuff_align_ctrl_pkg.sv
// Shared frontend definitions: parcel width, compressed-detect rule and
// the instruction-length encoding that predecode also uses.
package ibuff_align_ctrl_pkg;

    localparam int PARCEL_W = 16;

    typedef logic [PARCEL_W-1:0] parcel_t;

    typedef enum logic {
        ILEN_16 = 1'b0,
        ILEN_32 = 1'b1
    } inst_len_e;

    function automatic logic is_compressed(input parcel_t p);
        return p[1:0] != 2'b11;
    endfunction

    function automatic inst_len_e inst_len(input parcel_t p);
        return is_compressed(p) ? ILEN_16 : ILEN_32;
    endfunction

endpackage

// File: rtl/ibuff_align_ctrl_parcel_fifo.sv
// Circular parcel buffer: up to two parcels pushed and one or two popped
// per cycle, with the two head entries exposed for decode.
module ibuff_align_ctrl_parcel_fifo
    import ibuff_align_ctrl_pkg::*;
#(
    parameter int QDEPTH = 8,
    localparam int AW = $clog2(QDEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic [1:0]    push_n_i,
    input  parcel_t       push_a_i,
    input  parcel_t       push_b_i,
    input  logic          pop_i,
    input  logic          pop_two_i,
    output parcel_t       head0_o,
    output parcel_t       head1_o,
    output logic [CW-1:0] count_o
);

    parcel_t       mem_q [QDEPTH];
    parcel_t       mem_d [QDEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;
    logic [1:0]    pop_n;

    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);
    assign pop_n   = !pop_i ? 2'd0 : (pop_two_i ? 2'd2 : 2'd1);

    assign head0_o = mem_q[head_q];
    assign head1_o = mem_q[head_p1];
    assign count_o = count_q;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_n_i != 2'd0) begin
                mem_d[tail_q] = push_a_i;
            end
            if (push_n_i == 2'd2) begin
                mem_d[tail_p1] = push_b_i;
            end
            tail_d  = tail_q + AW'(push_n_i);
            head_d  = head_q + AW'(pop_n);
            count_d = count_q + CW'(push_n_i) - CW'(pop_n);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ibuff_align_ctrl.sv
// Parcel-aligning instruction buffer between fetch and predecode:
// queues fetch parcels and issues one 16- or 32-bit instruction per cycle.
module ibuff_align_ctrl
    import ibuff_align_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              QDEPTH   = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            fetch_valid,
    input  logic [31:0]     fetch_data,
    output logic            fetch_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_compressed
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            skip_lo_q, skip_lo_d;
    logic [CW-1:0]   count;
    parcel_t         h0, h1;
    logic            need2;
    logic            push_fire;
    logic            pop_fire;
    logic [1:0]      push_n;
    parcel_t         push_a;
    logic            unused_flush_pc0;

    assign unused_flush_pc0 = flush_pc[0];

    assign need2       = (inst_len(h0) == ILEN_32);
    assign fetch_ready = !flush && (count <= CW'(QDEPTH - 2));
    assign out_valid   = !flush && (count >= CW'(1))
                         && (!need2 || count >= CW'(2));

    assign push_fire = fetch_valid && fetch_ready;
    assign pop_fire  = out_valid && out_ready;

    // After a redirect to a half-word target the low parcel is not part
    // of the stream, so only the upper parcel of that fetch is queued.
    assign push_n = !push_fire ? 2'd0 : (skip_lo_q ? 2'd1 : 2'd2);
    assign push_a = skip_lo_q ? fetch_data[31:16] : fetch_data[15:0];

    ibuff_align_ctrl_parcel_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clr_i     (flush),
        .push_n_i  (push_n),
        .push_a_i  (push_a),
        .push_b_i  (fetch_data[31:16]),
        .pop_i     (pop_fire),
        .pop_two_i (need2),
        .head0_o   (h0),
        .head1_o   (h1),
        .count_o   (count)
    );

    always_comb begin
        out_inst       = '0;
        out_compressed = 1'b1;
        if (out_valid) begin
            out_compressed = !need2;
            out_inst       = need2 ? {h1, h0} : {16'h0, h0};
        end
    end

    assign out_pc = pc_q;

    always_comb begin
        pc_d      = pc_q;
        skip_lo_d = skip_lo_q;
        if (flush) begin
            pc_d      = {flush_pc[XLEN-1:1], 1'b0};
            skip_lo_d = flush_pc[1];
        end else begin
            if (pop_fire) begin
                pc_d = pc_q + (need2 ? XLEN'(4) : XLEN'(2));
            end
            if (push_fire) begin
                skip_lo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            skip_lo_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            skip_lo_q <= skip_lo_d;
        end
    end

endmodule

// File: tb/tb_ibuff_align_ctrl.sv
// Scoreboard bench for ibuff_align_ctrl: a parcel-stream reference model
// forms expected instructions; a negedge monitor compares DUT outputs.
module tb_ibuff_align_ctrl;

    localparam int          QD  = 8;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        fetch_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_compressed;

    ibuff_align_ctrl #(
        .XLEN     (32),
        .QDEPTH   (QD),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .fetch_ready    (fetch_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_compressed (out_compressed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        c;
        int          len;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] pend[$];
    int          cnt = 0;
    logic [31:0] mpc = RPC;
    bit          mskip = 0;
    bit          acc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, req, $time);
        end
    endtask

    function automatic void model_push(input logic [15:0] p);
        exp_t e;
        cnt++;
        if (pend.size() == 0) begin
            if (p[1:0] != 2'b11) begin
                e.inst = {16'h0, p};
                e.pc = mpc;
                e.c = 1'b1;
                e.len = 1;
                expq.push_back(e);
                mpc = mpc + 2;
            end else begin
                pend.push_back(p);
            end
        end else begin
            e.inst = {p, pend[0]};
            e.pc = mpc;
            e.c = 1'b0;
            e.len = 2;
            expq.push_back(e);
            mpc = mpc + 4;
            pend.delete();
        end
    endfunction

    function automatic void model_clear(input logic [31:0] pc,
                                        input bit sk);
        expq.delete();
        pend.delete();
        cnt = 0;
        mpc = pc;
        mskip = sk;
    endfunction

    // Model update at the clock edge, from the inputs held this cycle.
    always @(posedge clk) begin
        if (rst) begin
            if (flush) begin
                model_clear({flush_pc[31:1], 1'b0}, flush_pc[1]);
            end else if (acc) begin
                if (!mskip) model_push(fetch_data[15:0]);
                model_push(fetch_data[31:16]);
                mskip = 0;
            end
        end
    end

    // Monitor: compare outputs mid-cycle and retire issued instructions.
    always @(negedge clk) begin
        bit expv;
        expv = rst && !flush && (expq.size() > 0);
        chk("out_valid", {31'h0, out_valid}, {31'h0, expv});
        chk("fetch_ready", {31'h0, fetch_ready},
            {31'h0, !flush && (cnt <= QD - 2)});
        if (expv) begin
            chk("out_inst", out_inst, expq[0].inst);
            chk("out_pc", out_pc, expq[0].pc);
            chk("out_compressed", {31'h0, out_compressed},
                {31'h0, expq[0].c});
            if (out_ready) begin
                cnt -= expq[0].len;
                void'(expq.pop_front());
            end
        end else begin
            chk("idle_inst", out_inst, 32'h0);
            chk("idle_compressed", {31'h0, out_compressed}, 32'h1);
            if (!flush) chk("idle_pc", out_pc, mpc);
        end
    end

    task automatic step(input bit fv, input logic [31:0] fd,
                        input bit ordy, input bit fl,
                        input logic [31:0] fpc);
        @(posedge clk);
        #2;
        fetch_valid = fv;
        fetch_data  = fd;
        out_ready   = ordy;
        flush       = fl;
        flush_pc    = fpc;
        acc = rst && fv && !fl && (cnt <= QD - 2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 1, 0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        fetch_valid = 0;
        out_ready = 0;
        flush = 0;
        acc = 0;
        model_clear(RPC, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    function automatic logic [15:0] rand_parcel();
        logic [15:0] p;
        p = 16'($urandom);
        if ($urandom_range(1, 0) == 1) p[1:0] = 2'b11;
        else if (p[1:0] == 2'b11) p[1:0] = 2'b01;
        return p;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;

        step(1, 32'h0041_0513, 1, 0, 32'h0);
        idle(2);
        step(1, 32'h4505_4501, 1, 0, 32'h0);
        idle(3);
        step(1, 32'h0513_4501, 1, 0, 32'h0);
        idle(3);
        step(1, 32'h1234_0041, 1, 0, 32'h0);
        idle(3);
        step(0, 32'h0, 1, 1, 32'h0000_0102);
        step(1, 32'h4505_4501, 1, 0, 32'h0);
        idle(2);

        for (int i = 0; i < 8; i++) step(1, 32'h4505_4501 + i, 0, 0, 32'h0);
        idle(20);

        step(0, 32'h0, 0, 1, 32'h0000_0002);
        for (int i = 0; i < 3; i++) step(1, 32'h4505_4501, 0, 0, 32'h0);
        do_reset();
        idle(2);

        step(1, 32'h4505_4501, 1, 0, 32'h0);
        step(0, 32'h0, 1, 1, 32'h0000_0040);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399, 0) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(3, 0) != 0,
                     {rand_parcel(), rand_parcel()},
                     $urandom_range(2, 0) != 0,
                     $urandom_range(59, 0) == 0,
                     $urandom);
            end
        end

        for (int i = 0; i < 40 && expq.size() != 0; i++) idle(1);
        chk("drain_empty", expq.size(), 32'h0);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
